// File: rtl/vga_timing.sv
// Raster timing generator: x/y pixel counters plus de/hsync/vsync/frame_tick strobes,
// all registered and decoded from the next counter state so every output is cycle-aligned.
module vga_timing #(
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33,
  parameter bit HS_POL   = 1'b0,
  parameter bit VS_POL   = 1'b0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        pix_ce,
  output logic [15:0] x,
  output logic [15:0] y,
  output logic        de,
  output logic        hsync,
  output logic        vsync,
  output logic        frame_tick
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [15:0] H_LAST   = 16'(H_TOTAL - 1);
  localparam logic [15:0] V_LAST   = 16'(V_TOTAL - 1);
  localparam logic [15:0] H_VIS    = 16'(H_ACTIVE);
  localparam logic [15:0] V_VIS    = 16'(V_ACTIVE);
  localparam logic [15:0] HS_BEGIN = 16'(H_ACTIVE + H_FP);
  localparam logic [15:0] HS_STOP  = 16'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [15:0] VS_BEGIN = 16'(V_ACTIVE + V_FP);
  localparam logic [15:0] VS_STOP  = 16'(V_ACTIVE + V_FP + V_SYNC);

  logic [15:0] x_next;
  logic [15:0] y_next;
  logic        line_wrap;
  logic        de_next;
  logic        hs_on_next;
  logic        vs_on_next;
  logic        tick_next;

  always_comb begin
    line_wrap = (x == H_LAST);
    x_next    = line_wrap ? 16'd0 : x + 16'd1;
    y_next    = y;
    if (line_wrap) begin
      y_next = (y == V_LAST) ? 16'd0 : y + 16'd1;
    end
  end

  // Strobes look at the counter values being loaded, so they land on the same edge.
  always_comb begin
    de_next    = (x_next < H_VIS) && (y_next < V_VIS);
    hs_on_next = (x_next >= HS_BEGIN) && (x_next < HS_STOP);
    vs_on_next = (y_next >= VS_BEGIN) && (y_next < VS_STOP);
    tick_next  = (x_next == 16'd0) && (y_next == 16'd0);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      x          <= H_LAST;
      y          <= V_LAST;
      de         <= 1'b0;
      hsync      <= ~HS_POL;
      vsync      <= ~VS_POL;
      frame_tick <= 1'b0;
    end else if (pix_ce) begin
      x          <= x_next;
      y          <= y_next;
      de         <= de_next;
      hsync      <= hs_on_next ? HS_POL : ~HS_POL;
      vsync      <= vs_on_next ? VS_POL : ~VS_POL;
      frame_tick <= tick_next;
    end else begin
      // Held pixel: tick must not repeat while x/y sit at the frame origin.
      frame_tick <= 1'b0;
    end
  end

endmodule
